// File: rtl/single_port_ram_core_if.sv
// Bus bundle for the single-port RAM core: one shared address, write data,
// an operation select and the registered read data.
interface single_port_ram_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output en,
    output addr,
    output data_in,
    input  data
  );

  modport slave (
    input  en,
    input  addr,
    input  data_in,
    output data
  );
endinterface

// File: rtl/single_port_ram_core.sv
// Synchronous single-port RAM: en=1 writes mem[addr], en=0 loads mem[addr]
// into the output register. Synchronous reset clears every word and the output.
module single_port_ram_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  single_port_ram_core_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DEPTH-1:0]      wr_sel;

  // Every word must clear on reset, so storage is built from individually
  // resettable registers rather than a block RAM.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      assign wr_sel[gi] = bus.en && (bus.addr == ADDR_WIDTH'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (wr_sel[gi]) begin
          mem_reg[gi] <= bus.data_in;
        end
      end
    end
  endgenerate

  // Output only updates on a read; a write leaves the last read value in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
    end else if (!bus.en) begin
      data_reg <= mem_reg[bus.addr];
    end
  end

  assign bus.data = data_reg;
endmodule

// File: tb/tb_single_port_ram_core.sv
// Directed bench for single_port_ram_core: linear steps with hand-computed
// expected read data, checked by immediate assertions.
module tb_single_port_ram_core;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  single_port_ram_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  single_port_ram_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic cycle(input logic r, input logic e, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    rst         = r;
    bus.en      = e;
    bus.addr    = a;
    bus.data_in = d;
    @(posedge clk);
    #1;
    $display("step rst=%0b en=%0b addr=%0d data_in=%h -> data=%h", r, e, a, d, bus.data);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] exp);
    checks++;
    assert (bus.data === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, bus.data, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst         = 1'b1;
    bus.en      = 1'b1;
    bus.addr    = 4'd3;
    bus.data_in = 8'hFF;

    // Reset with a write attempt pending on the bus
    cycle(1'b1, 1'b1, 4'd3, 8'hFF);
    cycle(1'b1, 1'b1, 4'd3, 8'hFF);
    chk("reset_data", 8'h00);
    cycle(1'b0, 1'b0, 4'd3, 8'h00);
    chk("reset_blocks_write", 8'h00);

    // Sequential writes, reversed reads
    cycle(1'b0, 1'b1, 4'd0, 8'h24);
    cycle(1'b0, 1'b1, 4'd1, 8'h81);
    cycle(1'b0, 1'b1, 4'd2, 8'h09);
    cycle(1'b0, 1'b1, 4'd3, 8'h63);
    cycle(1'b0, 1'b1, 4'd4, 8'h0D);
    chk("no_write_through", 8'h00);
    cycle(1'b0, 1'b0, 4'd5, 8'h00);
    chk("read_a5", 8'h00);
    cycle(1'b0, 1'b0, 4'd4, 8'h00);
    chk("read_a4", 8'h0D);
    cycle(1'b0, 1'b0, 4'd3, 8'h00);
    chk("read_a3", 8'h63);
    cycle(1'b0, 1'b0, 4'd2, 8'h00);
    chk("read_a2", 8'h09);
    cycle(1'b0, 1'b0, 4'd1, 8'h00);
    chk("read_a1", 8'h81);

    // Inputs change between edges: output must not follow combinationally
    bus.addr = 4'd0;
    #2;
    chk("no_comb_path", 8'h81);

    // Hold during write
    cycle(1'b0, 1'b1, 4'd7, 8'hAA);
    chk("hold_on_write", 8'h81);
    cycle(1'b0, 1'b0, 4'd7, 8'h00);
    chk("read_a7", 8'hAA);

    // Overwrite and boundary addresses
    cycle(1'b0, 1'b1, 4'd15, 8'h5A);
    cycle(1'b0, 1'b1, 4'd15, 8'hC3);
    cycle(1'b0, 1'b1, 4'd0, 8'h11);
    cycle(1'b0, 1'b0, 4'd15, 8'h00);
    chk("read_a15_overwrite", 8'hC3);
    cycle(1'b0, 1'b0, 4'd0, 8'h00);
    chk("read_a0_overwrite", 8'h11);

    // Back-to-back alternation
    cycle(1'b0, 1'b1, 4'd2, 8'h3C);
    chk("hold_before_alt", 8'h11);
    cycle(1'b0, 1'b0, 4'd2, 8'h00);
    chk("alt_read1", 8'h3C);
    cycle(1'b0, 1'b1, 4'd2, 8'h7E);
    chk("alt_hold", 8'h3C);
    cycle(1'b0, 1'b0, 4'd2, 8'h00);
    chk("alt_read2", 8'h7E);

    // Reset mid-operation clears contents and output
    cycle(1'b1, 1'b0, 4'd2, 8'h00);
    chk("midreset_data", 8'h00);
    cycle(1'b0, 1'b0, 4'd2, 8'h00);
    chk("midreset_a2", 8'h00);
    cycle(1'b0, 1'b0, 4'd7, 8'h00);
    chk("midreset_a7", 8'h00);
    cycle(1'b0, 1'b0, 4'd15, 8'h00);
    chk("midreset_a15", 8'h00);

    // Memory still writable after reset
    cycle(1'b0, 1'b1, 4'd9, 8'hB6);
    cycle(1'b0, 1'b0, 4'd9, 8'h00);
    chk("post_reset_write", 8'hB6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/single_port_ram_core.md
Name: single_port_ram_core

Overview:
Synchronous single-port RAM with one shared address bus, a write-data input and a registered read-data output. A single enable selects the operation each cycle: high writes, low reads. Used as a small scratch/storage memory in the memories library; depth is 2**ADDR_WIDTH words of DATA_WIDTH bits.

Parameters:
DATA_WIDTH, 8, width of each memory word and of data_in/data.
ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH (16 words by default).

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous active-high reset.
en  input  1  operation select: 1 = write, 0 = read.
addr  input  ADDR_WIDTH  word address for both write and read.
data_in  input  DATA_WIDTH  write data, sampled when en=1.
data  output  DATA_WIDTH  registered read data.

Behaviour:
- Storage: array mem[0 .. 2**ADDR_WIDTH-1] of DATA_WIDTH-bit words, plus output register data_q driving data.
- Reset (rst=1 at rising edge): data_q <= 0; every mem word <= 0. rst has priority over en; no write and no read occur in a reset cycle. Reset mid-operation discards any pending access; contents written before reset are lost.
- Write (rst=0, en=1 at rising edge): mem[addr] <= data_in. data_q holds its previous value (no write-through).
- Read (rst=0, en=0 at rising edge): data_q <= mem[addr]. One-cycle latency: data is valid after the rising edge that sampled addr, held stable until the next read or reset.
- Write followed by read of same address on the next cycle returns the newly written value.
- Any address 0 .. 2**ADDR_WIDTH-1 is valid; no out-of-range condition exists (addr width equals depth width). No wrap logic needed.
- Never-written locations read 0 after reset.
- Inputs en, addr and data_in are sampled only at the rising edge; there is no combinational path from inputs to data.
- X/Z on en with rst=0: implementation may leave state undefined. Benches must drive en to a known level after reset.
- Power-up before first reset: contents and data are undefined. Benches must apply reset first.

Test Plan:
- Reset: hold rst=1 for 2 cycles with en=1, addr=3, data_in=8'hFF -> data=0; a subsequent read of addr 3 returns 8'h00, so the write was blocked.
- Sequential writes and reversed reads: write addr 0..4 with 8'h24, 8'h81, 8'h09, 8'h63, 8'h0D. Then read addr 5,4,3,2,1 -> data one cycle later = 8'h00, 8'h0D, 8'h63, 8'h09, 8'h81.
- Hold during write: read addr 1 (data=8'h81), then write addr 7=8'hAA -> data stays 8'h81. A following read of addr 7 gives 8'hAA.
- Overwrite and boundary addresses: write addr 15=8'h5A, then addr 15=8'hC3, addr 0=8'h11. Read 15 -> 8'hC3; read 0 -> 8'h11.
- Back-to-back alternation: write addr 2=8'h3C, read addr 2 on the very next cycle -> 8'h3C after one edge. Write addr 2=8'h7E, read -> 8'h7E.
- Reset mid-operation: after the writes above, assert rst for one cycle -> data=0. Reads of addr 2, 7 and 15 all return 8'h00.
